// File: rtl/fetch_aligner.sv
// -----------------------------------------------------------------------------
// fetch_aligner
//
// Front-end block between the instruction memory read port and the
// compressed-instruction expander. Fetches word-aligned 32-bit words, splits
// them into halfwords, rejoins 32-bit instructions that straddle a word
// boundary and presents one instruction per valid/ready handshake.
//
// Ports:
//   clk            core clock, all state on the rising edge
//   reset          asynchronous, active-high reset
//   fetch_en       read request to instruction memory this cycle
//   fetch_addr     word-aligned read address
//   fetch_rdata    read data, valid the cycle after fetch_en
//   redirect_valid single-cycle branch/jump/trap redirect
//   redirect_pc    redirect target (halfword aligned)
//   out_valid      instruction available
//   out_ready      consumer accepts
//   out_instr      instruction; compressed ones sit in [15:0], [31:16]=0
//   out_is_c       1 = 16-bit instruction
//   out_pc         address of out_instr
// -----------------------------------------------------------------------------
module fetch_aligner #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        fetch_en,
    output logic [31:0] fetch_addr,
    input  logic [31:0] fetch_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_is_c,
    output logic [31:0] out_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // One buffered fetch word; off=1 means only the upper halfword is live
    // (the word was fetched for an odd-halfword redirect target).
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        off;
    } entry_t;

    entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_empty;
    entry_t            head;

    logic              inflight;
    logic [31:0]       req_pc;
    logic              first_off;

    // Halfword buffer: a leftover upper half waiting to be emitted or joined.
    logic              hb_valid;
    logic [15:0]       hb_data;
    logic [31:0]       hb_pc;

    logic              sel_valid;
    logic [31:0]       sel_instr;
    logic              sel_is_c;
    logic [31:0]       sel_pc;
    logic              sel_pop;
    logic              sel_load_hb;
    logic              sel_clear_hb;
    logic              sel_silent;

    logic              advance;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occ_after;

    // Bit 0 of a halfword-aligned target is always zero and carries no state.
    logic              unused_redirect_bit;
    assign unused_redirect_bit = redirect_pc[0];

    function automatic logic is_c(input logic [1:0] low_bits);
        return low_bits != 2'b11;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned and a latch is inferred.
    always_comb begin
        sel_valid    = 1'b0;
        sel_instr    = '0;
        sel_is_c     = 1'b0;
        sel_pc       = '0;
        sel_pop      = 1'b0;
        sel_load_hb  = 1'b0;
        sel_clear_hb = 1'b0;
        sel_silent   = 1'b0;
        if (hb_valid) begin
            if (is_c(hb_data[1:0])) begin
                sel_valid    = 1'b1;
                sel_instr    = {16'h0000, hb_data};
                sel_is_c     = 1'b1;
                sel_pc       = hb_pc;
                sel_clear_hb = 1'b1;
            end else if (!fifo_empty) begin
                // Straddling instruction: low half in hb, high half at head.
                sel_valid   = 1'b1;
                sel_instr   = {head.data[15:0], hb_data};
                sel_pc      = hb_pc;
                sel_pop     = 1'b1;
                sel_load_hb = 1'b1;
            end
        end else if (!fifo_empty) begin
            if (!head.off) begin
                if (is_c(head.data[1:0])) begin
                    sel_valid   = 1'b1;
                    sel_instr   = {16'h0000, head.data[15:0]};
                    sel_is_c    = 1'b1;
                    sel_pc      = head.pc;
                    sel_pop     = 1'b1;
                    sel_load_hb = 1'b1;
                end else begin
                    sel_valid = 1'b1;
                    sel_instr = head.data;
                    sel_pc    = head.pc;
                    sel_pop   = 1'b1;
                end
            end else if (is_c(head.data[17:16])) begin
                sel_valid = 1'b1;
                sel_instr = {16'h0000, head.data[31:16]};
                sel_is_c  = 1'b1;
                sel_pc    = head.pc + 32'd2;
                sel_pop   = 1'b1;
            end else begin
                // Upper half starts a 32-bit instruction: park it in hb
                // without producing an output.
                sel_pop     = 1'b1;
                sel_load_hb = 1'b1;
                sel_silent  = 1'b1;
            end
        end
    end

    assign out_valid = sel_valid && !redirect_valid;
    assign out_instr = sel_instr;
    assign out_is_c  = sel_is_c;
    assign out_pc    = sel_pc;

    assign advance = (out_valid && out_ready) || (sel_silent && !redirect_valid);
    assign pop     = advance && sel_pop;
    // A response arriving in a redirect cycle is the killed one: drop it.
    assign push    = inflight && !redirect_valid;

    // Room check counts the word already in flight so the FIFO cannot overflow.
    assign occ_after = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    assign fetch_en  = !reset && !redirect_valid &&
                       (occ_after < (CNT_W + 1)'(FIFO_DEPTH));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            inflight   <= 1'b0;
            req_pc     <= '0;
            first_off  <= RESET_PC[1];
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hb_valid   <= 1'b0;
            hb_data    <= '0;
            hb_pc      <= '0;
        end else if (redirect_valid) begin
            fetch_addr <= {redirect_pc[31:2], 2'b00};
            inflight   <= 1'b0;
            first_off  <= redirect_pc[1];
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hb_valid   <= 1'b0;
        end else begin
            inflight <= fetch_en;
            if (fetch_en) begin
                req_pc     <= fetch_addr;
                fetch_addr <= fetch_addr + 32'd4;
            end
            if (push) begin
                wr_ptr    <= ptr_next(wr_ptr);
                first_off <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (advance) begin
                if (sel_load_hb) begin
                    hb_valid <= 1'b1;
                    hb_data  <= head.data[31:16];
                    hb_pc    <= head.pc + 32'd2;
                end else if (sel_clear_hb) begin
                    hb_valid <= 1'b0;
                end
            end
        end
    end

    // NOTE: the word storage has no reset; count/pointers decide which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{data: fetch_rdata, pc: req_pc, off: first_off};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && count == FULL_CNT));
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// -----------------------------------------------------------------------------
// tb_fetch_aligner
//
// Self-checking bench for fetch_aligner: a behavioural instruction memory with
// 1-cycle read latency, a scoreboard queue of expected instructions and a
// monitor that compares every accepted output against the queue head.
// -----------------------------------------------------------------------------
module tb_fetch_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FILL_WORD = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_is_c;
    logic [31:0] out_pc;

    typedef struct {
        logic [31:0] instr;
        logic        is_c;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          stall    = 1'b0;

    fetch_aligner #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .fetch_addr     (fetch_addr),
        .fetch_rdata    (fetch_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_is_c       (out_is_c),
        .out_pc         (out_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : FILL_WORD;
    endfunction

    // Instruction memory: request seen mid-cycle, data presented next cycle.
    initial begin
        logic        req;
        logic [31:0] addr;
        fetch_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            req  = fetch_en;
            addr = fetch_addr;
            @(posedge clk);
            #1;
            fetch_rdata = req ? mem_word(addr) : 32'hDEAD_BEEF;
        end
    end

    // Consumer: ready only while the scoreboard still expects something.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = (exp_q.size() != 0) && !stall;
        end
    end

    // Monitor: every handshake is compared with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                    check("out_is_c", 32'(out_is_c), 32'(e.is_c));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_instr(input logic [31:0] instr, input logic is_c, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.is_c  = is_c;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        exp_q.delete();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fetch_en", 32'(fetch_en), 32'd0);
        check("rst_fetch_addr", fetch_addr, RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit found;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // ---- all compressed, plus startup latency ---------------------------
        mem.delete();
        mem[32'h0] = 32'h4505_0001;
        mem[32'h4] = 32'h4585_4501;
        do_reset();
        expect_instr(32'h0000_0001, 1'b1, 32'h0);
        expect_instr(32'h0000_4505, 1'b1, 32'h2);
        expect_instr(32'h0000_4501, 1'b1, 32'h4);
        expect_instr(32'h0000_4585, 1'b1, 32'h6);
        @(negedge clk);
        check("c0_fetch_en", 32'(fetch_en), 32'd1);
        check("c0_fetch_addr", fetch_addr, 32'h0);
        check("c0_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("c1_fetch_addr", fetch_addr, 32'h4);
        check("c1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("c2_out_valid", 32'(out_valid), 32'd1);
        drain("drain_all_c", 40);

        // ---- aligned 32-bit -------------------------------------------------
        mem.delete();
        mem[32'h0] = 32'h0010_0093;
        mem[32'h4] = 32'h0020_0113;
        do_reset();
        expect_instr(32'h0010_0093, 1'b0, 32'h0);
        expect_instr(32'h0020_0113, 1'b0, 32'h4);
        drain("drain_aligned", 40);

        // ---- straddle -------------------------------------------------------
        mem.delete();
        mem[32'h0] = 32'h0093_0001;
        mem[32'h4] = 32'h4505_0010;
        do_reset();
        expect_instr(32'h0000_0001, 1'b1, 32'h0);
        expect_instr(32'h0010_0093, 1'b0, 32'h2);
        expect_instr(32'h0000_4505, 1'b1, 32'h6);
        drain("drain_straddle", 40);

        // ---- odd redirect ---------------------------------------------------
        mem.delete();
        mem[32'h100] = 32'h0001_FFFF;
        mem[32'h104] = 32'h0010_0093;
        do_reset();
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        @(negedge clk);
        check("redir_out_valid", 32'(out_valid), 32'd0);
        check("redir_fetch_en", 32'(fetch_en), 32'd0);
        tick();
        redirect_valid = 1'b0;
        expect_instr(32'h0000_0001, 1'b1, 32'h102);
        expect_instr(32'h0010_0093, 1'b0, 32'h104);
        @(negedge clk);
        check("redir_resume_en", 32'(fetch_en), 32'd1);
        check("redir_fetch_addr", fetch_addr, 32'h100);
        drain("drain_odd_redirect", 40);

        // ---- backpressure ---------------------------------------------------
        mem.delete();
        mem[32'h0]  = 32'h4505_0001;
        mem[32'h4]  = 32'h0093_4501;
        mem[32'h8]  = 32'h4585_0010;
        mem[32'hC]  = 32'h0020_0113;
        mem[32'h10] = 32'h4505_0001;
        do_reset();
        expect_instr(32'h0000_0001, 1'b1, 32'h0);
        expect_instr(32'h0000_4505, 1'b1, 32'h2);
        expect_instr(32'h0000_4501, 1'b1, 32'h4);
        expect_instr(32'h0010_0093, 1'b0, 32'h6);
        expect_instr(32'h0000_4585, 1'b1, 32'hA);
        expect_instr(32'h0020_0113, 1'b0, 32'hC);
        expect_instr(32'h0000_0001, 1'b1, 32'h10);
        expect_instr(32'h0000_4505, 1'b1, 32'h12);
        for (int i = 0; i < 40 && exp_q.size() > 6; i++) tick();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_instr", out_instr, exp_q[0].instr);
            check("bp_hold_pc", out_pc, exp_q[0].pc);
            if (i == 5) check("bp_fetch_stopped", 32'(fetch_en), 32'd0);
        end
        tick();
        stall = 1'b0;
        drain("drain_backpressure", 60);

        // ---- kill in-flight response ----------------------------------------
        mem.delete();
        mem[32'h0]   = 32'h0010_0093;
        mem[32'h4]   = 32'h0020_0113;
        mem[32'h8]   = 32'h00A0_0513;
        mem[32'h200] = 32'h0030_0193;
        do_reset();
        expect_instr(32'h0010_0093, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (fetch_en && fetch_addr == 32'h8) found = 1'b1;
        end
        check("kill_fetch8_seen", 32'(found), 32'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        expect_instr(32'h0030_0193, 1'b0, 32'h200);
        drain("drain_kill", 40);

        // ---- reset mid-stream -----------------------------------------------
        mem.delete();
        mem[32'h0] = 32'h4505_0001;
        mem[32'h4] = 32'h4585_4501;
        do_reset();
        expect_instr(32'h0000_0001, 1'b1, 32'h0);
        expect_instr(32'h0000_4505, 1'b1, 32'h2);
        expect_instr(32'h0000_4501, 1'b1, 32'h4);
        expect_instr(32'h0000_4585, 1'b1, 32'h6);
        for (int i = 0; i < 40 && exp_q.size() > 2; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_fetch_en", 32'(fetch_en), 32'd0);
        check("midrst_fetch_addr", fetch_addr, RESET_PC);
        exp_q.delete();
        tick();
        reset = 1'b0;
        expect_instr(32'h0000_0001, 1'b1, 32'h0);
        expect_instr(32'h0000_4505, 1'b1, 32'h2);
        expect_instr(32'h0000_4501, 1'b1, 32'h4);
        expect_instr(32'h0000_4585, 1'b1, 32'h6);
        @(negedge clk);
        check("midrst_restart_en", 32'(fetch_en), 32'd1);
        check("midrst_restart_addr", fetch_addr, RESET_PC);
        drain("drain_after_reset", 40);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
